// File: rtl/pyr_flow_div_26s_17s_9s_seq.sv
// rtl/pyr_flow_div_26s_17s_9s_seq.sv - sequential signed 26s/17s divider with saturated 9s quotient
module pyr_flow_div_26s_17s_9s_seq #(
  parameter int DIVIDEND_W = 26,
  parameter int DIVISOR_W  = 17,
  parameter int QUOT_W     = 9
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0] QPOS_LIM = DIVIDEND_W'((1 << (QUOT_W - 1)) - 1);
  localparam logic [DIVIDEND_W-1:0] QNEG_LIM = DIVIDEND_W'(1 << (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]     Q_MAX    = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN    = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [DIVIDEND_W-1:0]   dvq_q, dvq_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]    part_q, part_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    quot_neg_q, quot_neg_d;
  logic                    rem_neg_q, rem_neg_d;
  logic                    dbz_flag_q, dbz_flag_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [QUOT_W-1:0]       quot_q, quot_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic                    ovf_q, ovf_d;
  logic                    dbz_q, dbz_d;

  logic [DIVISOR_W:0]      part_sh;
  logic                    part_ge;
  logic [DIVISOR_W-1:0]    part_nx;
  logic [DIVIDEND_W-1:0]   dvq_nx;

  // dvq holds the dividend magnitude; quotient bits enter at the LSB as dividend bits leave the MSB
  always_comb begin
    part_sh = {part_q, dvq_q[DIVIDEND_W-1]};
    part_ge = part_sh >= {1'b0, dvs_q};
    part_nx = part_ge ? DIVISOR_W'(part_sh - {1'b0, dvs_q}) : part_sh[DIVISOR_W-1:0];
    dvq_nx  = {dvq_q[DIVIDEND_W-2:0], part_ge};
  end

  always_comb begin
    state_d     = state_q;
    dvq_d       = dvq_q;
    dvs_d       = dvs_q;
    part_d      = part_q;
    cnt_d       = cnt_q;
    quot_neg_d  = quot_neg_q;
    rem_neg_d   = rem_neg_q;
    dbz_flag_d  = dbz_flag_q;
    out_valid_d = out_valid_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    ovf_d       = ovf_q;
    dbz_d       = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          dvq_d      = dividend[DIVIDEND_W-1] ? -dividend : dividend;
          dvs_d      = divisor[DIVISOR_W-1] ? -divisor : divisor;
          quot_neg_d = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
          rem_neg_d  = dividend[DIVIDEND_W-1];
          dbz_flag_d = (divisor == '0);
          part_d     = '0;
          cnt_d      = CNT_W'(DIVIDEND_W - 1);
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        dvq_d  = dvq_nx;
        part_d = part_nx;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          if (dbz_flag_q) begin
            quot_d = rem_neg_q ? Q_MIN : Q_MAX;
            rem_d  = '0;
            ovf_d  = 1'b0;
            dbz_d  = 1'b1;
          end else begin
            dbz_d = 1'b0;
            rem_d = rem_neg_q ? -part_nx : part_nx;
            if (!quot_neg_q && (dvq_nx > QPOS_LIM)) begin
              quot_d = Q_MAX;
              ovf_d  = 1'b1;
            end else if (quot_neg_q && (dvq_nx > QNEG_LIM)) begin
              quot_d = Q_MIN;
              ovf_d  = 1'b1;
            end else begin
              quot_d = quot_neg_q ? -dvq_nx[QUOT_W-1:0] : dvq_nx[QUOT_W-1:0];
              ovf_d  = 1'b0;
            end
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      dvq_q       <= '0;
      dvs_q       <= '0;
      part_q      <= '0;
      cnt_q       <= '0;
      quot_neg_q  <= 1'b0;
      rem_neg_q   <= 1'b0;
      dbz_flag_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else if (ce) begin
      state_q     <= state_d;
      dvq_q       <= dvq_d;
      dvs_q       <= dvs_d;
      part_q      <= part_d;
      cnt_q       <= cnt_d;
      quot_neg_q  <= quot_neg_d;
      rem_neg_q   <= rem_neg_d;
      dbz_flag_q  <= dbz_flag_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      dbz_q       <= dbz_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign ovf       = ovf_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_pyr_flow_div_26s_17s_9s_seq.sv
// tb/tb_pyr_flow_div_26s_17s_9s_seq.sv - vector table plus randomized reference-model bench for the divider
module tb_pyr_flow_div_26s_17s_9s_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [25:0] dividend;
  logic [16:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  quot;
  logic [16:0] rem;
  logic        ovf;
  logic        dbz;

  int tests = 0;
  int fails = 0;

  always #5 ap_clk = ~ap_clk;

  pyr_flow_div_26s_17s_9s_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ovf       (ovf),
    .dbz       (dbz)
  );

  typedef struct {
    longint a;
    longint b;
    int     stall_at;
    int     stall_len;
    int     hold;
    longint eq;
    longint er;
    int     eo;
    int     ed;
  } vec_t;

  task automatic chk(input string nm, input longint got, input longint exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Reference: plain integer division truncating toward zero, then clamp to the 9-bit signed range
  function automatic void model(input longint a, input longint b,
                                output longint q, output longint r, output int o, output int d);
    longint qq;
    if (b == 0) begin
      d = 1; o = 0; r = 0;
      q = (a >= 0) ? 255 : -256;
    end else begin
      d  = 0;
      qq = a / b;
      r  = a % b;
      if (qq > 255) begin q = 255; o = 1; end
      else if (qq < -256) begin q = -256; o = 1; end
      else begin q = qq; o = 0; end
    end
  endfunction

  task automatic run_op(input longint a, input longint b, input int stall_at, input int stall_len,
                        input int hold, output longint gq, output longint gr, output int go,
                        output int gd, output int lat, output int bad);
    int w;
    bad = 0;
    w   = 0;
    while (!in_ready && w < 50) begin
      @(negedge ap_clk);
      w++;
    end
    if (!in_ready) bad++;
    dividend  = a[25:0];
    divisor   = b[16:0];
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      if (in_ready) bad++;
      if (lat == stall_at) ce = 1'b0;
      if (lat == stall_at + stall_len) ce = 1'b1;
      @(posedge ap_clk);
      @(negedge ap_clk);
      lat++;
    end
    ce = 1'b1;
    gq = $signed(quot);
    gr = $signed(rem);
    go = int'(ovf);
    gd = int'(dbz);
    for (int i = 0; i < hold; i++) begin
      if (!out_valid || in_ready || $signed(quot) != gq || $signed(rem) != gr ||
          int'(ovf) != go || int'(dbz) != gd) bad++;
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    out_ready = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    out_ready = 1'b0;
    if (out_valid || !in_ready) bad++;
  endtask

  vec_t   tbl[16];
  longint gq, gr, mq, mr;
  int     go, gd, mo, md, lat, bad;

  initial begin
    tbl[0]  = '{100, 7, -1, 0, 0, 14, 2, 0, 0};
    tbl[1]  = '{-100, 7, -1, 0, 0, -14, -2, 0, 0};
    tbl[2]  = '{100, -7, -1, 0, 0, -14, 2, 0, 0};
    tbl[3]  = '{100000, 3, -1, 0, 0, 255, 1, 1, 0};
    tbl[4]  = '{-33554432, -65536, -1, 0, 0, 255, 0, 1, 0};
    tbl[5]  = '{-256, 1, -1, 0, 0, -256, 0, 0, 0};
    tbl[6]  = '{5, 0, -1, 0, 0, 255, 0, 0, 1};
    tbl[7]  = '{-5, 0, -1, 0, 0, -256, 0, 0, 1};
    tbl[8]  = '{100, 7, -1, 0, 10, 14, 2, 0, 0};
    tbl[9]  = '{100, 7, 5, 5, 0, 14, 2, 0, 0};
    tbl[10] = '{256, 1, -1, 0, 0, 255, 0, 1, 0};
    tbl[11] = '{257, -1, -1, 0, 0, -256, 0, 1, 0};
    tbl[12] = '{-7, -2, -1, 0, 0, 3, -1, 0, 0};
    tbl[13] = '{65535, -65536, -1, 0, 0, 0, 65535, 0, 0};
    tbl[14] = '{33554431, 65535, -1, 0, 0, 255, 511, 1, 0};
    tbl[15] = '{-33554432, 1, -1, 0, 0, -256, 0, 1, 0};

    ap_rst_n  = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #12;
    chk("rst_in_ready", longint'(in_ready), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_quot", longint'(quot), 0);
    chk("rst_rem", longint'(rem), 0);
    chk("rst_ovf_dbz", longint'({ovf, dbz}), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    chk("post_rst_in_ready", longint'(in_ready), 1);

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].stall_at, tbl[i].stall_len, tbl[i].hold,
             gq, gr, go, gd, lat, bad);
      chk($sformatf("tbl%0d_quot", i), gq, tbl[i].eq);
      chk($sformatf("tbl%0d_rem", i), gr, tbl[i].er);
      chk($sformatf("tbl%0d_ovf", i), go, tbl[i].eo);
      chk($sformatf("tbl%0d_dbz", i), gd, tbl[i].ed);
      chk($sformatf("tbl%0d_latency", i), lat, 27 + tbl[i].stall_len);
      chk($sformatf("tbl%0d_handshake", i), bad, 0);
    end

    // ce low while idle: the valid operand pair must not be sampled
    ce       = 1'b0;
    dividend = 26'd100;
    divisor  = 17'd7;
    in_valid = 1'b1;
    repeat (3) @(negedge ap_clk);
    in_valid = 1'b0;
    ce       = 1'b1;
    repeat (30) @(negedge ap_clk);
    chk("ce_idle_no_result", longint'(out_valid), 0);
    chk("ce_idle_in_ready", longint'(in_ready), 1);

    for (int n = 0; n < 150; n++) begin
      logic [25:0] ra;
      logic [16:0] rb;
      longint a, b;
      int mode, sa, sl;
      ra   = 26'($urandom);
      rb   = 17'($urandom);
      mode = $urandom_range(0, 3);
      a    = $signed(ra);
      b    = $signed(rb);
      if (mode == 1) b = longint'($urandom_range(0, 40)) - 20;
      if (mode == 2) begin
        a = longint'($urandom_range(0, 20000)) - 10000;
        b = longint'($urandom_range(1, 300)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
      end
      if (mode == 3) begin
        case ($urandom_range(0, 3))
          0: a = -33554432;
          1: a = 33554431;
          2: b = -65536;
          default: b = 0;
        endcase
      end
      sa = $urandom_range(1, 26);
      sl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      model(a, b, mq, mr, mo, md);
      run_op(a, b, sa, sl, $urandom_range(0, 2), gq, gr, go, gd, lat, bad);
      chk($sformatf("rnd%0d_quot a=%0d b=%0d", n, a, b), gq, mq);
      chk($sformatf("rnd%0d_rem a=%0d b=%0d", n, a, b), gr, mr);
      chk($sformatf("rnd%0d_ovf", n), go, mo);
      chk($sformatf("rnd%0d_dbz", n), gd, md);
      chk($sformatf("rnd%0d_latency", n), lat, 27 + sl);
      chk($sformatf("rnd%0d_handshake", n), bad, 0);
    end

    // Reset in the middle of a calculation, with non-zero held outputs from the previous result
    run_op(-5, 0, -1, 0, 0, gq, gr, go, gd, lat, bad);
    chk("pre_rst_quot", gq, -256);
    dividend = 26'd100;
    divisor  = 17'd7;
    in_valid = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    in_valid = 1'b0;
    repeat (10) @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", longint'(out_valid), 0);
    chk("midrst_quot", longint'(quot), 0);
    chk("midrst_rem", longint'(rem), 0);
    chk("midrst_ovf_dbz", longint'({ovf, dbz}), 0);
    chk("midrst_in_ready", longint'(in_ready), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    chk("after_rst_no_stale", longint'(out_valid), 0);
    run_op(100, 7, -1, 0, 0, gq, gr, go, gd, lat, bad);
    chk("after_rst_quot", gq, 14);
    chk("after_rst_rem", gr, 2);
    chk("after_rst_latency", lat, 27);
    chk("after_rst_handshake", bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
